// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of a single-port register file
// between NUM_REQ masters, one transaction per grant, registered outputs.
module regfile_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rf_write,
    output logic                      rf_read,
    output logic [ADDR_W-1:0]         rf_addr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [DATA_W-1:0]         rf_rdata,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ARB,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [PTR_W-1:0]     w_win;
    logic [PTR_W-1:0]     w_k;
    logic                 w_found;
    logic [2:0]           r_cnt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_rvalid;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_rf_write;
    logic                 r_rf_read;
    logic [ADDR_W-1:0]    r_rf_addr;
    logic [DATA_W-1:0]    r_rf_wdata;
    logic                 r_busy;

    assign gnt      = r_gnt;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign rf_write = r_rf_write;
    assign rf_read  = r_rf_read;
    assign rf_addr  = r_rf_addr;
    assign rf_wdata = r_rf_wdata;
    assign busy     = r_busy;

    // Pick the first requester after the last winner; nearest offset wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_k     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_k = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
            if (req[w_k]) begin
                w_found = 1'b1;
                w_win   = w_k;
            end
        end
    end

    // Next-state: a write returns straight to ARB, a read waits for data.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB:   if (w_found) w_state_nxt = ISSUE;
            ISSUE: w_state_nxt = r_rf_write ? ARB : WAIT;
            WAIT:  if (r_cnt == 3'd1) w_state_nxt = RESP;
            RESP:  w_state_nxt = ARB;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ARB;
        else       r_state <= w_state_nxt;
    end

    // Registered strobes, capture of the winner and read-data return.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= PTR_W'(NUM_REQ - 1);
            r_owner    <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
            r_rf_write <= 1'b0;
            r_rf_read  <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_rf_write <= 1'b0;
            r_rf_read  <= 1'b0;
            r_busy     <= (w_state_nxt != ARB);
            unique case (r_state)
                ARB: begin
                    if (w_found) begin
                        r_owner      <= w_win;
                        r_ptr        <= w_win;
                        r_gnt[w_win] <= 1'b1;
                        r_rf_write   <= req_we[w_win];
                        r_rf_read    <= ~req_we[w_win];
                        r_rf_addr    <= req_addr[w_win*ADDR_W +: ADDR_W];
                        r_rf_wdata   <= req_wdata[w_win*DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    if (!r_rf_write) r_cnt <= 3'(RD_LATENCY);
                end
                WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_rdata           <= rf_rdata;
                        r_rvalid[r_owner] <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RESP: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed and random stimulus for regfile_arbiter,
// checked every cycle against a transaction-level schedule model.
module tb_regfile_arbiter;

    localparam int N = 4;
    localparam int L = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   req_we;
    logic [N*8-1:0] req_addr;
    logic [N*8-1:0] req_wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rvalid;
    logic [7:0]     rdata;
    logic           rf_write;
    logic           rf_read;
    logic [7:0]     rf_addr;
    logic [7:0]     rf_wdata;
    logic [7:0]     rf_rdata;
    logic           busy;

    always #5 clk = ~clk;

    regfile_arbiter #(
        .NUM_REQ   (N),
        .ADDR_W    (8),
        .DATA_W    (8),
        .RD_LATENCY(L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .rf_write (rf_write),
        .rf_read  (rf_read),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata),
        .busy     (busy)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         wr;
        logic         rd;
        logic [7:0]   addr;
        logic [7:0]   wdata;
        logic [N-1:0] rvalid;
        logic [7:0]   rdata;
    } exp_t;

    exp_t       slots [16];
    logic [7:0] rom [256];
    logic       h_v [8];
    logic [7:0] h_a [8];
    int         cyc;
    int         nerr;
    int         nchk;
    int         m_free;
    int         m_last;
    logic       m_known;
    logic [7:0] m_rdata;
    logic [N-1:0] m_granted;
    logic [N-1:0] pend;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Transaction-level model: when free, grant the nearest requester after
    // the last winner and schedule its strobe, response and busy window.
    task automatic model_step();
        exp_t       e;
        int         w;
        logic [1:0] idx;
        logic [7:0] a;
        m_granted = '0;
        if (reset) begin
            for (int s = 0; s < 16; s++) slots[s] = '0;
            m_free  = cyc + 1;
            m_last  = N - 1;
            m_rdata = 8'h00;
            m_known = 1'b1;
        end else if (m_known && cyc >= m_free && req != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                idx = 2'((m_last + k) % N);
                if (w < 0 && req[idx]) w = int'(idx);
            end
            a = req_addr[w*8 +: 8];
            e = slots[4'(cyc + 1)];
            e.gnt[w] = 1'b1;
            e.wr     = req_we[w];
            e.rd     = ~req_we[w];
            e.addr   = a;
            e.wdata  = req_wdata[w*8 +: 8];
            slots[4'(cyc + 1)] = e;
            if (!req_we[w]) begin
                e = slots[4'(cyc + 2 + L)];
                e.rvalid[w] = 1'b1;
                e.rdata     = rom[a];
                slots[4'(cyc + 2 + L)] = e;
                m_free = cyc + 3 + L;
            end else begin
                m_free = cyc + 2;
            end
            m_last = w;
            m_granted[w] = 1'b1;
        end
    endtask

    task automatic compare();
        exp_t e;
        if (m_known) begin
            e = slots[4'(cyc)];
            if (e.rvalid != '0) m_rdata = e.rdata;
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("rvalid", 32'(rvalid), 32'(e.rvalid));
            chk("rf_write", 32'(rf_write), 32'(e.wr));
            chk("rf_read", 32'(rf_read), 32'(e.rd));
            chk("busy", 32'(busy), 32'(cyc < m_free));
            chk("rdata", 32'(rdata), 32'(m_rdata));
            if (e.wr || e.rd) chk("rf_addr", 32'(rf_addr), 32'(e.addr));
            if (e.wr) chk("rf_wdata", 32'(rf_wdata), 32'(e.wdata));
            slots[4'(cyc)] = '0;
        end
    endtask

    // Regfile stand-in: data valid exactly L cycles after rf_read, junk else.
    task automatic rf_drive();
        for (int i = 7; i > 0; i--) begin
            h_v[i] = h_v[i-1];
            h_a[i] = h_a[i-1];
        end
        h_v[0] = rf_read;
        h_a[0] = rf_addr;
        rf_rdata = (h_v[L] === 1'b1) ? rom[h_a[L]] : 8'($urandom);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        cyc++;
        compare();
        rf_drive();
    endtask

    task automatic set_req(input int i, input logic r, input logic we,
                           input logic [7:0] a, input logic [7:0] d);
        req[i]           = r;
        req_we[i]        = we;
        req_addr[i*8+:8] = a;
        req_wdata[i*8+:8] = d;
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        nerr = 0; nchk = 0; cyc = 0;
        m_free = 0; m_last = N - 1; m_known = 1'b0;
        m_rdata = 8'h00; m_granted = '0; pend = '0;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[8'h05] = 8'hA5;
        rom[8'h33] = 8'h3C;
        for (int s = 0; s < 16; s++) slots[s] = '0;
        for (int i = 0; i < 8; i++) begin
            h_v[i] = 1'b0;
            h_a[i] = 8'h00;
        end
        reset = 1'b1; req = '0; req_we = '0;
        req_addr = '0; req_wdata = '0; rf_rdata = 8'h00;
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        tick();
        reset = 1'b0;

        // Both write: requester 0 first, then 1 two cycles later.
        set_req(0, 1'b1, 1'b1, 8'h10, 8'h11);
        set_req(1, 1'b1, 1'b1, 8'h20, 8'h22);
        tick();
        chk("t1_gnt0", 32'(gnt), 32'h1);
        chk("t1_wr0", 32'(rf_write), 32'h1);
        chk("t1_addr0", 32'(rf_addr), 32'h10);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        chk("t1_gnt1", 32'(gnt), 32'h2);
        chk("t1_addr1", 32'(rf_addr), 32'h20);
        chk("t1_wdata1", 32'(rf_wdata), 32'h22);
        idle(4);

        // Read of 0x05 returns 0xA5 at T+2+L, only to requester 0.
        set_req(0, 1'b1, 1'b0, 8'h05, 8'h00);
        tick();
        chk("t2_rd", 32'(rf_read), 32'h1);
        chk("t2_addr", 32'(rf_addr), 32'h05);
        req = '0;
        for (int i = 0; i < L; i++) begin
            tick();
            chk("t2_norv", 32'(rvalid), 32'h0);
        end
        tick();
        chk("t2_rvalid", 32'(rvalid), 32'h1);
        chk("t2_rdata", 32'(rdata), 32'hA5);
        idle(4);

        // Two requesters held high: grants alternate 1,0,1,0...
        set_req(0, 1'b1, 1'b1, 8'h40, 8'h41);
        set_req(1, 1'b1, 1'b1, 8'h50, 8'h51);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t3_alt", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h1);
            tick();
        end
        idle(4);

        // Read by 1, write by 0 raised mid-read waits until after RESP.
        set_req(1, 1'b1, 1'b0, 8'h33, 8'h00);
        tick();
        chk("t4_gnt1", 32'(gnt), 32'h2);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(0, 1'b1, 1'b1, 8'h44, 8'h55);
        tick();
        tick();
        tick();
        chk("t4_wait", 32'(gnt), 32'h0);
        tick();
        chk("t4_rvalid", 32'(rvalid), 32'h2);
        chk("t4_rdata", 32'(rdata), 32'h3C);
        tick();
        chk("t4_arb", 32'(gnt), 32'h0);
        tick();
        chk("t4_gnt0", 32'(gnt), 32'h1);
        chk("t4_addr0", 32'(rf_addr), 32'h44);
        idle(4);

        // Reset during WAIT drops the read and restores requester-0 priority.
        set_req(1, 1'b1, 1'b0, 8'h07, 8'h00);
        tick();
        req = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_gnt", 32'(gnt), 32'h0);
        chk("t5_rvalid", 32'(rvalid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_rdata", 32'(rdata), 32'h0);
        chk("t5_addr", 32'(rf_addr), 32'h0);
        set_req(0, 1'b1, 1'b1, 8'h66, 8'h77);
        set_req(1, 1'b1, 1'b1, 8'h68, 8'h79);
        tick();
        chk("t5_gnt0", 32'(gnt), 32'h1);
        idle(6);

        // Pointer wrap: after 3 wins, 0 beats 3.
        set_req(3, 1'b1, 1'b1, 8'h30, 8'h31);
        tick();
        chk("t6_gnt3", 32'(gnt), 32'h8);
        set_req(0, 1'b1, 1'b1, 8'h01, 8'h02);
        set_req(3, 1'b1, 1'b1, 8'h3A, 8'h3B);
        tick();
        tick();
        chk("t6_gnt0", 32'(gnt), 32'h1);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        chk("t6_gnt3b", 32'(gnt), 32'h8);
        chk("t6_addr3", 32'(rf_addr), 32'h3A);
        idle(6);

        // Random traffic obeying the hold-until-grant protocol.
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            pend = pend & ~m_granted;
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        pend[i] = 1'b1;
                        set_req(i, 1'b1, 1'($urandom),
                                8'($urandom), 8'($urandom));
                    end else begin
                        set_req(i, 1'b0, 1'($urandom),
                                8'($urandom), 8'($urandom));
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    pend[i] = 1'b0;
                    req[i]  = 1'b0;
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        idle(10);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
